// File: rtl/uart_axis_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_axis_rx
// Description : UART receiver feeding an 8-bit AXI-Stream master port.
//               Deserialises 8N1 frames (8E1 when UART_RX_PARITY_EN is
//               defined) from rxd, checks framing, buffers good bytes in a
//               small FIFO and presents them with a valid/ready handshake.
//
//   Parameters
//     CLK_FREQ      clock frequency in Hz
//     BAUD_RATE     serial bit rate
//     FIFO_DEPTH    byte FIFO entries (power of two, >= 2)
//
//   Ports
//     clk            in   system clock, rising edge
//     arst           in   asynchronous active-high reset
//     rxd            in   serial input, asynchronous, idle high
//     m_axis_tdata   out  FIFO head byte (0 when empty)
//     m_axis_tvalid  out  FIFO non-empty
//     m_axis_tready  in   downstream accept
//     frame_err      out  one-cycle pulse: stop bit sampled low
//     overflow       out  one-cycle pulse: good byte dropped, FIFO full
//     parity_err     out  one-cycle pulse: even-parity check failed
//                         (present only with UART_RX_PARITY_EN)
//
//   Optional feature macro: UART_RX_PARITY_EN
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_axis_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       rxd,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       frame_err,
    output logic       overflow
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int c_CPB   = CLK_FREQ / BAUD_RATE;
    localparam int c_CNT_W = (c_CPB > 1) ? $clog2(c_CPB) : 1;
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(c_CPB / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_M1 = c_CNT_W'(c_CPB - 1);
    localparam int c_AW    = $clog2(FIFO_DEPTH);
    localparam int c_PW    = c_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer; resets to the idle (high) line level so a reset
    // release never looks like a start bit.
    // ------------------------------------------------------------------
    logic [1:0] r_sync;
    logic       w_rxs;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rxd};
        end
    end

    assign w_rxs = r_sync[1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               w_half_tick;
    logic               w_full_tick;
    logic               w_cnt_clr;
    logic               w_shift_en;
    logic               w_push;
    logic               w_ferr_set;
`ifdef UART_RX_PARITY_EN
    logic               r_par_bit;
    logic               w_par_en;
    logic               w_perr_set;
`endif

    assign w_half_tick = (r_cnt == c_HALF_M1);
    assign w_full_tick = (r_cnt == c_FULL_M1);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_push       = 1'b0;
        w_ferr_set   = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_en     = 1'b0;
        w_perr_set   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // Counter held at zero so START measures from the edge.
                w_cnt_clr = 1'b1;
                if (!w_rxs) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_half_tick) begin
                    w_cnt_clr    = 1'b1;
                    // High at mid-bit means a glitch: drop back silently.
                    w_state_next = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_full_tick) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_full_tick) begin
                    w_cnt_clr    = 1'b1;
                    w_par_en     = 1'b1;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_full_tick) begin
                    w_cnt_clr = 1'b1;
                    if (!w_rxs) begin
                        // Framing error takes precedence over parity.
                        w_ferr_set   = 1'b1;
                        w_state_next = S_BREAK;
                    end else begin
                        // Return at mid-stop so back-to-back frames align.
                        w_state_next = S_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (^{r_shift, r_par_bit}) begin
                            w_perr_set = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
`else
                        w_push = 1'b1;
`endif
                    end
                end
            end
            S_BREAK: begin
                // A line held low must return high before a new start.
                w_cnt_clr = 1'b1;
                if (w_rxs) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state != S_DATA) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift_en) begin
                r_shift[r_bit_idx] <= w_rxs;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_par_bit <= 1'b0;
        end else if (w_par_en) begin
            r_par_bit <= w_rxs;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Byte FIFO; the extra pointer MSB separates full from empty.
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_wr_en;
    logic            w_drop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = m_axis_tvalid && m_axis_tready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is kept.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= r_shift;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign m_axis_tvalid = !w_empty;
    // Masking with empty keeps tdata at zero out of reset without
    // having to reset the storage array.
    assign m_axis_tdata  = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_AW-1:0]];

    // ------------------------------------------------------------------
    // Error pulses, registered so they land one cycle after the sample.
    // ------------------------------------------------------------------
    logic r_frame_err;
    logic r_overflow;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_frame_err <= w_ferr_set;
            r_overflow  <= w_drop;
        end
    end

    assign frame_err = r_frame_err;
    assign overflow  = r_overflow;

`ifdef UART_RX_PARITY_EN
    logic r_parity_err;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_perr_set;
        end
    end

    assign parity_err = r_parity_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_axis_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_axis_rx
// Description : Self-checking bench for uart_axis_rx. A 16-deep instance
//               covers reset, single frames, streaming, glitch, framing and
//               mid-frame reset; a 4-deep instance covers overflow.
//               Received beats are checked against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_axis_rx;

    localparam int c_CPB = 100;
`ifdef UART_RX_PARITY_EN
    localparam int c_NBITS = 10;
`else
    localparam int c_NBITS = 9;
`endif
    // rxd edge -> sync (2) -> IDLE exit (1) -> mid-start -> bits to stop sample
    localparam int c_LAT = 3 + c_CPB / 2 + c_NBITS * c_CPB;

    logic       clk = 1'b0;
    logic       arst;
    logic       rxd, rxd4;
    logic       tready, tready4;
    logic [7:0] tdata, tdata4;
    logic       tvalid, tvalid4;
    logic       ferr, ferr4;
    logic       ovf, ovf4;
`ifdef UART_RX_PARITY_EN
    logic       perr, perr4;
    bit         par_flip = 1'b0;
`endif

    uart_axis_rx #(
        .CLK_FREQ  (100_000_000),
        .BAUD_RATE (1_000_000),
        .FIFO_DEPTH(16)
    ) dut (
        .clk          (clk),
`ifdef UART_RX_PARITY_EN
        .parity_err   (perr),
`endif
        .arst         (arst),
        .rxd          (rxd),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .frame_err    (ferr),
        .overflow     (ovf)
    );

    uart_axis_rx #(
        .CLK_FREQ  (100_000_000),
        .BAUD_RATE (1_000_000),
        .FIFO_DEPTH(4)
    ) u_dut4 (
        .clk          (clk),
`ifdef UART_RX_PARITY_EN
        .parity_err   (perr4),
`endif
        .arst         (arst),
        .rxd          (rxd4),
        .m_axis_tdata (tdata4),
        .m_axis_tvalid(tvalid4),
        .m_axis_tready(tready4),
        .frame_err    (ferr4),
        .overflow     (ovf4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard / monitors
    // ------------------------------------------------------------------
    logic [7:0] exp_q[$];
    logic [7:0] got4[$];
    int   beats = 0, ferr_cnt = 0, ovf_cnt = 0, ovf4_cnt = 0, perr_cnt = 0;
    int   rise_cyc = -1, ferr_cyc = -1, ovf4_cyc = -1, perr_cyc = -1;
    logic prev_valid = 1'b0, prev_stall = 1'b0, prev_ferr = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clk) begin
        if (arst) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
            prev_ferr  = 1'b0;
        end else begin
            if (tvalid && !prev_valid) rise_cyc = cyc;
            if (prev_stall && tvalid) check("stall_stable", tdata, prev_data);
            if (tvalid && tready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", tdata);
                end else begin
                    check("beat_data", tdata, exp_q.pop_front());
                end
            end
            if (ferr) begin
                ferr_cnt++;
                ferr_cyc = cyc;
                check("ferr_one_cycle", {31'b0, prev_ferr}, 32'd0);
            end
            if (ovf) ovf_cnt++;
            if (ovf4) begin
                ovf4_cnt++;
                ovf4_cyc = cyc;
            end
            if (tvalid4 && tready4) got4.push_back(tdata4);
`ifdef UART_RX_PARITY_EN
            if (perr) begin
                perr_cnt++;
                perr_cyc = cyc;
            end
`endif
            prev_valid = tvalid;
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_ferr  = ferr;
        end
    end

    // ------------------------------------------------------------------
    // Frame driver
    // ------------------------------------------------------------------
    int last_start = 0;

    task automatic drive(input bit which, input logic v);
        if (which) rxd4 = v;
        else       rxd  = v;
    endtask

    task automatic send(input bit which, input logic [7:0] d, input bit stop_ok);
        @(posedge clk);
        #1;
        last_start = cyc;
        drive(which, 1'b0);
        repeat (c_CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 drive(which, d[i]);
            repeat (c_CPB) @(posedge clk);
        end
`ifdef UART_RX_PARITY_EN
        #1 drive(which, (^d) ^ par_flip);
        repeat (c_CPB) @(posedge clk);
`endif
        #1 drive(which, stop_ok);
        repeat (c_CPB) @(posedge clk);
        #1 drive(which, 1'b1);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         exp_byte;
        bit         exp_ferr;
    } vec_t;

    vec_t       vecs[8];
    logic [7:0] stream[5];
    int         b0, f0;

    initial begin
        vecs[0] = '{8'hC0, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h88, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h43, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'hA8, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h5A, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{8'h43, 1'b1, 1'b1, 1'b0};
        stream[0] = 8'hC0; stream[1] = 8'h88; stream[2] = 8'h43;
        stream[3] = 8'hA8; stream[4] = 8'h43;

        // Reset with rxd toggling
        rxd = 1'b1; rxd4 = 1'b1; tready = 1'b1; tready4 = 1'b0; arst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1 rxd = ~rxd;
        end
        @(negedge clk);
        check("rst_tvalid", {31'b0, tvalid}, 32'd0);
        check("rst_tdata", {24'b0, tdata}, 32'd0);
        check("rst_ferr", {31'b0, ferr}, 32'd0);
        check("rst_ovf", {31'b0, ovf}, 32'd0);
        check("rst_tvalid4", {31'b0, tvalid4}, 32'd0);
        @(posedge clk);
        #1 rxd = 1'b1; arst = 1'b0;
        repeat (1200) @(posedge clk);
        check("post_rst_no_beat", beats, 0);

        // Table-driven frames, tready held high
        for (int i = 0; i < 8; i++) begin
            b0 = beats;
            f0 = ferr_cnt;
            if (vecs[i].exp_byte) exp_q.push_back(vecs[i].data);
            send(1'b0, vecs[i].data, vecs[i].stop_ok);
            repeat (5) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_beats", i), beats - b0, {31'b0, vecs[i].exp_byte});
            check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, {31'b0, vecs[i].exp_ferr});
            if (vecs[i].exp_byte)
                check($sformatf("vec%0d_latency", i), rise_cyc - last_start, c_LAT);
            if (vecs[i].exp_ferr)
                check($sformatf("vec%0d_ferr_time", i), ferr_cyc - last_start, c_LAT);
        end

        // Start glitch: 20 low cycles, then a good frame
        b0 = beats;
        f0 = ferr_cnt;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (20) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("glitch_no_beat", beats - b0, 0);
        check("glitch_no_ferr", ferr_cnt - f0, 0);
        exp_q.push_back(8'h43);
        send(1'b0, 8'h43, 1'b1);
        repeat (5) @(posedge clk);
        check("post_glitch_beat", beats - b0, 1);

        // Back-to-back stream while stalled, then release
        #1 tready = 1'b0;
        b0 = beats;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(stream[i]);
            send(1'b0, stream[i], 1'b1);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_valid", {31'b0, tvalid}, 32'd1);
        check("stall_head", {24'b0, tdata}, 32'hC0);
        @(posedge clk);
        #1 tready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("drain_nogap%0d", k), {31'b0, tvalid}, 32'd1);
        end
        @(negedge clk);
        check("drain_empty", {31'b0, tvalid}, 32'd0);
        check("drain_beats", beats - b0, 5);

        // Overflow on the 4-deep instance
        for (int i = 0; i < 5; i++) begin
            send(1'b1, stream[i] ^ 8'h11, 1'b1);
            repeat (3) @(posedge clk);
            if (i == 3) check("ovf_before_5th", ovf4_cnt, 0);
        end
        check("ovf_count", ovf4_cnt, 1);
        check("ovf_time", ovf4_cyc - last_start, c_LAT);
        @(posedge clk);
        #1 tready4 = 1'b1;
        repeat (20) @(posedge clk);
        check("ovf_drain_count", got4.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (got4.size() > i)
                check($sformatf("ovf_drain%0d", i), {24'b0, got4[i]}, {24'b0, stream[i] ^ 8'h11});
        end

        // Reset mid-frame with a byte waiting in the FIFO
        #1 tready = 1'b0;
        send(1'b0, 8'h55, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_valid", {31'b0, tvalid}, 32'd1);
        check("pre_rst_data", {24'b0, tdata}, 32'h55);
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (350) @(posedge clk);
        #1 arst = 1'b1; rxd = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_valid", {31'b0, tvalid}, 32'd0);
        check("midrst_data", {24'b0, tdata}, 32'd0);
        @(posedge clk);
        #1 arst = 1'b0; tready = 1'b1;
        b0 = beats;
        repeat (1500) @(posedge clk);
        check("midrst_no_beat", beats - b0, 0);

`ifdef UART_RX_PARITY_EN
        // Even parity good, then flipped
        b0 = beats;
        exp_q.push_back(8'hA8);
        par_flip = 1'b0;
        send(1'b0, 8'hA8, 1'b1);
        repeat (5) @(posedge clk);
        check("par_ok_beat", beats - b0, 1);
        b0 = beats;
        f0 = perr_cnt;
        par_flip = 1'b1;
        send(1'b0, 8'hA8, 1'b1);
        repeat (5) @(posedge clk);
        check("par_bad_no_beat", beats - b0, 0);
        check("par_bad_perr", perr_cnt - f0, 1);
        check("par_bad_time", perr_cyc - last_start, c_LAT);
        par_flip = 1'b0;
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        check("no_main_overflow", ovf_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
